// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage register.
// State encoding, default NOP payload and default stall-counter width.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

    localparam int PIPE_CNT_W = 8;

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        FULL  = ST_FULL,
        SKID  = ST_SKID
    } stage_state_t;

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating count of consecutive stalled edges.
// Clears on any edge without a counted stall.
module pipe_stall_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = PIPE_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!inc) begin
            cnt <= '0;
        end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with a 2-entry skid, stall and bubble.
// Define STALL_CNT_EN to add the stall_cnt output and its saturating counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(PIPE_NOP)
`ifdef STALL_CNT_EN
    ,
    parameter int               CNT_W      = PIPE_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             stall,
    input  logic             bubble
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    stage_state_t     state_q;
    stage_state_t     state_nx;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_nx;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_nx;
    logic             skid_valid;
    logic             accept;
    logic             deq;

    assign skid_valid = (state_q == SKID);
    assign out_valid  = (state_q != EMPTY);
    assign out_data   = main_q;

    // Ready depends only on state and hazard controls, never on the handshakes.
    assign in_ready = ~reset & ~skid_valid & ~stall & ~bubble;
    assign accept   = in_valid & in_ready;
    assign deq      = out_valid & out_ready & ~stall & ~bubble;

    always_comb begin
        state_nx = state_q;
        main_nx  = main_q;
        skid_nx  = skid_q;
        if (bubble) begin
            state_nx = EMPTY;
            main_nx  = BUBBLE_VAL;
            skid_nx  = BUBBLE_VAL;
        end else if (!stall) begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_nx = FULL;
                        main_nx  = in_data;
                    end
                end
                FULL: begin
                    unique case ({accept, deq})
                        2'b11: main_nx = in_data;
                        2'b10: begin
                            state_nx = SKID;
                            skid_nx  = in_data;
                        end
                        2'b01: begin
                            state_nx = EMPTY;
                            main_nx  = BUBBLE_VAL;
                        end
                        default: ;
                    endcase
                end
                SKID: begin
                    if (deq) begin
                        state_nx = FULL;
                        main_nx  = skid_q;
                        skid_nx  = BUBBLE_VAL;
                    end
                end
                default: begin
                    state_nx = EMPTY;
                    main_nx  = BUBBLE_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= BUBBLE_VAL;
        end else begin
            state_q <= state_nx;
            main_q  <= main_nx;
            skid_q  <= skid_nx;
        end
    end

`ifdef STALL_CNT_EN
    pipe_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall & ~bubble),
        .cnt   (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Random plus directed bench for pipe_stage_reg against a 2-deep FIFO model.
// Define STALL_CNT_EN to also check the saturating stall counter.
module tb_pipe_stage_reg;

    localparam int          W     = 32;
    localparam logic [31:0] R_VAL = 32'h0000_0bad;
    localparam logic [31:0] B_VAL = 32'h0000_0013;
    localparam int          CW    = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          stall = 1'b0;
    logic          bubble = 1'b0;
`ifdef STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Model: an ordered list of at most two held items.
    logic [31:0] q[$];
    logic [31:0] empty_val = R_VAL;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .WIDTH      (W),
        .RESET_VAL  (R_VAL),
        .BUBBLE_VAL (B_VAL)
`ifdef STALL_CNT_EN
        ,
        .CNT_W      (CW)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .stall     (stall),
        .bubble    (bubble)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !reset && q.size() < 2 && !stall && !bubble;
    endfunction

    task automatic check_outputs();
        check("in_ready", 32'(in_ready), 32'(m_ready()));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("out_data", out_data, (q.size() > 0) ? q[0] : empty_val);
`ifdef STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic model_reset();
        q.delete();
        empty_val = R_VAL;
        m_cnt = 0;
    endtask

    // Apply what the coming rising edge will do to the model.
    task automatic model_edge();
        bit acc;
        bit pop;
        if (reset) begin
            model_reset();
            return;
        end
        acc = in_valid && m_ready();
        if (bubble) begin
            q.delete();
            empty_val = B_VAL;
        end else if (!stall) begin
            pop = q.size() > 0 && out_ready;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(in_data);
            if (pop && q.size() == 0) empty_val = B_VAL;
        end
        if (stall && !bubble)
            m_cnt = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
        else
            m_cnt = 0;
    endtask

    task automatic cycle(input logic r, input logic iv, input logic [31:0] d,
                         input logic ordy, input logic st, input logic bb);
        @(negedge clk);
        reset     = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        bubble    = bb;
        #1;
        check_outputs();
        model_edge();
    endtask

    initial begin
        // Reset, then a streaming run.
        cycle(1, 0, 0, 1, 0, 0);
        cycle(1, 1, 32'h99, 1, 0, 0);
        cycle(0, 1, 4, 1, 0, 0);
        cycle(0, 1, 8, 1, 0, 0);
        cycle(0, 1, 12, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        // Fill the skid, then drain in order.
        cycle(0, 1, 4, 0, 0, 0);
        cycle(0, 1, 8, 0, 0, 0);
        cycle(0, 1, 9, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        // Stall with pending input.
        cycle(0, 1, 16, 1, 1, 0);
        cycle(0, 1, 16, 1, 1, 0);
        cycle(0, 1, 20, 1, 1, 0);
        cycle(0, 1, 16, 1, 0, 0);
        cycle(0, 1, 20, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        // Bubble over a full skid with a concurrent stall.
        cycle(0, 1, 24, 0, 0, 0);
        cycle(0, 1, 28, 0, 0, 0);
        cycle(0, 1, 32, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 0);
        // Long stall to saturate the counter.
        cycle(0, 1, 40, 0, 0, 0);
        repeat (5) cycle(0, 1, 44, 1, 1, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        // Reset asserted between edges while holding 28.
        cycle(0, 1, 28, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_valid", 32'(out_valid), 32'h0);
        check("async_data", out_data, R_VAL);
        check("async_ready", 32'(in_ready), 32'h0);
        cycle(1, 1, 50, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) != 0),
                  $urandom(),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 15) == 0));
        end
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generalised pipeline-stage register that replaces the fixed 32-bit fetch register. It carries a WIDTH-bit payload between any two pipeline stages. Upstream and downstream use a valid/ready handshake, with a 2-entry skid so that in_ready is driven only by state and the stall/bubble inputs. Global stall freezes the stage. Bubble flushes it to a NOP value.

Parameters:
WIDTH, 32, payload width in bits.
RESET_VAL, 0, out_data value after reset.
BUBBLE_VAL, 0, out_data value when the stage is empty or flushed (NOP encoding).
CNT_W, 8, width of the stall counter (optional feature only).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
in_data  in  WIDTH  payload from the upstream stage.
in_valid  in  1  upstream payload is valid.
in_ready  out  1  stage can accept this cycle.
out_data  out  WIDTH  registered payload to the downstream stage.
out_valid  out  1  out_data holds a valid entry.
out_ready  in  1  downstream consumes this cycle.
stall  in  1  hazard-unit freeze.
bubble  in  1  hazard-unit flush.
stall_cnt  out  CNT_W  consecutive-stall count (present only with STALL_CNT_EN).

Behaviour:
- Storage: main register (drives out_data/out_valid) plus skid register and skid_valid.
- States: EMPTY (main invalid), FULL (main valid, skid empty), SKID (both valid).
- While reset is high: state=EMPTY; out_data=RESET_VAL; out_valid=0; skid cleared; in_ready=0; stall_cnt=0. This holds asynchronously, including mid-transfer.
- in_ready = ~reset & ~skid_valid & ~stall & ~bubble. This is combinational only from state and the control inputs, never from in_valid or out_ready.
- accept = in_valid & in_ready.
- deq = out_valid & out_ready & ~stall & ~bubble.
- Priority: bubble > stall > handshake.
- bubble=1: at the next edge go to EMPTY. out_data=BUBBLE_VAL, out_valid=0, skid dropped. Concurrent input is not accepted. A simultaneous stall is ignored.
- stall=1, bubble=0: all registers hold. No accept and no dequeue.
- EMPTY, accept: go to FULL, main<=in_data. Latency is 1 cycle from accept to out_valid.
- FULL, accept & deq: stay FULL, main<=in_data. Full throughput is 1 item per cycle.
- FULL, accept & ~deq: go to SKID, skid<=in_data.
- FULL, ~accept & deq: go to EMPTY, main<=BUBBLE_VAL, out_valid=0.
- SKID: in_ready=0. On deq go to FULL with main<=skid. Otherwise hold.
- Ordering is strictly FIFO. No entry is duplicated or lost except through bubble.
- out_data is never X. It always holds RESET_VAL, BUBBLE_VAL or an accepted payload.

Optional Feature:
Macro STALL_CNT_EN.
- Defined: stall_cnt increments on each edge where stall=1 and bubble=0, saturating at all-ones. It clears to 0 on any edge where stall=0 or bubble=1. Reset value is 0.
- Undefined: the stall_cnt port and its counter are absent. All other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding localparams (ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2);
  - the default NOP constant used for BUBBLE_VAL;
  - the default CNT_W.
- One sub-module is natural: pipe_stall_counter (the saturating counter), instantiated only under STALL_CNT_EN.

Test Plan:
- Reset and flow: reset high 2 cycles, then stream 4,8,12 with out_ready=1 → out_data=0 during reset; 4,8,12 appear one cycle after each accept with out_valid=1; in_ready=1 throughout.
- Skid: accept 4, then 8 with out_ready=0 → state SKID, in_ready=0. Set out_ready=1 → 4 then 8 delivered in order with no loss.
- Stall: stall=1 for 3 cycles while in_valid carries 16,20 → out_data holds its previous value, in_ready=0, nothing consumed. After stall drops, 16 is accepted next.
- Bubble: bubble=1 with SKID holding 24,28 and stall=1 → next cycle out_valid=0, out_data=BUBBLE_VAL, in_ready=1 again.
- Async reset mid-transfer: assert reset between edges while FULL with 28 → out_valid=0 and out_data=RESET_VAL immediately, without waiting for a clock edge.
- STALL_CNT_EN with CNT_W=2: stall held 5 cycles → stall_cnt goes 1,2,3,3,3, then 0 on the first non-stall edge.
